display_share_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 8-digit seven-segment display path among three requesters.
- Requesters: 0 = access control (user ID entry), 1 = game (live score), 2 = scoreboard (stored scores).
- Replaces the static score mux in front of the seven-segment decoder.
- Enforces a minimum display hold time, supports a lock input from process control, and blanks the display when nobody owns it.

---
 rtl/display_share_arbiter.sv | 132 +++++++++++++
 tb/tb_display_share_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/display_share_arbiter.sv
// Round-robin owner of the shared seven-segment display path (ID entry, live score, stored scores).
// Enforces a minimum hold per owner, honours a process-control lock, and blanks the display when idle.
module display_share_arbiter #(
    parameter int          HOLD_CYCLES = 50000000,
    parameter logic [31:0] BLANK_VALUE = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        lock,
    output logic [2:0]  gnt,
    output logic [1:0]  owner,
    output logic [31:0] disp_data,
    output logic        disp_valid
);
    // state | meaning
    // IDLE  | nobody owns the display, blank value driven
    // OWN   | owner holds the display, data tracks its source every cycle
    typedef enum logic {IDLE, OWN} state_t;

    localparam int          CW   = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] HMAX = CW'(HOLD_CYCLES - 1);

    state_t        state, state_n;
    logic [CW-1:0] hold_cnt, hold_n;
    logic [1:0]    rr_ptr, rr_n;
    logic [2:0]    gnt_n;
    logic [1:0]    owner_n;
    logic [31:0]   data_n;
    logic          valid_n;

    logic [2:0]    cand;
    logic [1:0]    p0, p1, p2, win;
    logic          found;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [31:0] sel_data(input logic [1:0] i, input logic [31:0] d0,
                                             input logic [31:0] d1, input logic [31:0] d2);
        case (i)
            2'd0:    return d0;
            2'd1:    return d1;
            default: return d2;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = owner;
        data_n  = disp_data;
        valid_n = disp_valid;
        hold_n  = hold_cnt;
        rr_n    = rr_ptr;

        // The current owner never competes against itself in the search.
        cand  = (state == OWN) ? (req & ~gnt) : req;
        p0    = rr_ptr;
        p1    = next_idx(p0);
        p2    = next_idx(p1);
        found = 1'b1;
        if (cand[p0])      win = p0;
        else if (cand[p1]) win = p1;
        else if (cand[p2]) win = p2;
        else begin
            win   = 2'd0;
            found = 1'b0;
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_n = OWN;
                    gnt_n   = 3'b001 << win;
                    owner_n = win;
                    data_n  = sel_data(win, data0, data1, data2);
                    valid_n = 1'b1;
                    hold_n  = '0;
                    rr_n    = next_idx(win);
                end
            end
            OWN: begin
                if (!req[owner] || (!lock && hold_cnt == HMAX && found)) begin
                    if (found) begin
                        gnt_n   = 3'b001 << win;
                        owner_n = win;
                        data_n  = sel_data(win, data0, data1, data2);
                        hold_n  = '0;
                        rr_n    = next_idx(win);
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 3'b000;
                        owner_n = 2'b11;
                        data_n  = BLANK_VALUE;
                        valid_n = 1'b0;
                        hold_n  = '0;
                    end
                end else begin
                    data_n = sel_data(owner, data0, data1, data2);
                    if (!lock && hold_cnt != HMAX)
                        hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 3'b000;
            owner      <= 2'b11;
            disp_data  <= BLANK_VALUE;
            disp_valid <= 1'b0;
            hold_cnt   <= '0;
            rr_ptr     <= 2'd0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            owner      <= owner_n;
            disp_data  <= data_n;
            disp_valid <= valid_n;
            hold_cnt   <= hold_n;
            rr_ptr     <= rr_n;
        end
    end
endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with a short hold time of 4 cycles.
// Each step drives inputs, advances one edge, and checks outputs 1 ns later.
module tb_display_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [31:0] data0, data1, data2;
    logic        lock;
    logic [2:0]  gnt;
    logic [1:0]  owner;
    logic [31:0] disp_data;
    logic        disp_valid;

    int tests = 0;
    int fails = 0;

    display_share_arbiter #(.HOLD_CYCLES(4), .BLANK_VALUE(32'hFFFFFFFF)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
        .lock(lock), .gnt(gnt), .owner(owner), .disp_data(disp_data), .disp_valid(disp_valid)
    );

    always #5 clk = ~clk;

    // Advance one edge and check the one-hot / owner / valid consistency every cycle.
    task automatic tick();
        logic ok;
        @(posedge clk);
        #1;
        ok = ($countones(gnt) <= 1) && ((owner == 2'b11) == (gnt == 3'b000))
             && ((gnt == 3'b000) == !disp_valid);
        tests++;
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL invariant: gnt=%b owner=%0d valid=%b", gnt, owner, disp_valid);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [2:0] eg, input logic [1:0] eo);
        tests++;
        assert (gnt === eg && owner === eo) else begin
            fails++;
            $error("FAIL %s: gnt=%b owner=%0d expected gnt=%b owner=%0d", tag, gnt, owner, eg, eo);
        end
    endtask

    task automatic chk_data(input string tag, input logic [31:0] ed, input logic ev);
        tests++;
        assert (disp_data === ed && disp_valid === ev) else begin
            fails++;
            $error("FAIL %s: disp_data=%h valid=%b expected %h/%b", tag, disp_data, disp_valid, ed, ev);
        end
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; lock = 1'b0;
        data0 = 32'hAAAA0000; data1 = 32'h00000000; data2 = 32'h22220000;

        // 1: idle after reset
        tick(); tick();
        chk_gnt("reset_gnt", 3'b000, 2'b11);
        chk_data("reset_data", 32'hFFFFFFFF, 1'b0);
        rst = 1'b0;
        tick(); chk_gnt("idle_gnt", 3'b000, 2'b11);
        lock = 1'b1;
        tick(); chk_data("idle_data", 32'hFFFFFFFF, 1'b0);

        // 2: single grant (lock in IDLE has no effect), then tracking
        data1 = 32'h00001234; req = 3'b010;
        tick(); chk_gnt("grant1", 3'b010, 2'd1); chk_data("grant1_data", 32'h00001234, 1'b1);
        lock = 1'b0;
        data1 = 32'h00001235;
        tick(); chk_data("track1", 32'h00001235, 1'b1);
        tick(); tick();                           // hold_cnt now 3

        // 3: preemption rotates 2 -> 0 -> 1, four cycles apart
        req = 3'b111;
        tick(); chk_gnt("preempt_to2", 3'b100, 2'd2); chk_data("preempt_to2_data", 32'h22220000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_gnt("hold2", 3'b100, 2'd2);
        end
        tick(); chk_gnt("preempt_to0", 3'b001, 2'd0); chk_data("preempt_to0_data", 32'hAAAA0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_gnt("hold0", 3'b001, 2'd0);
        end
        tick(); chk_gnt("preempt_to1", 3'b010, 2'd1);
        for (int i = 0; i < 3; i++) tick();
        tick(); chk_gnt("rot_to2", 3'b100, 2'd2);
        for (int i = 0; i < 3; i++) tick();
        tick(); chk_gnt("rot_to0", 3'b001, 2'd0);
        tick(); tick(); tick();                   // owner 0, hold expired

        // 4: lock freezes owner 0
        lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); chk_gnt("locked0", 3'b001, 2'd0);
        end
        lock = 1'b0;
        tick(); chk_gnt("unlock_to1", 3'b010, 2'd1);

        // 5: release to idle, then release with a pending requester
        for (int i = 0; i < 3; i++) tick();
        tick(); chk_gnt("rot_to2b", 3'b100, 2'd2);
        req = 3'b100;
        tick(); chk_gnt("hold2b", 3'b100, 2'd2);
        req = 3'b000;
        tick(); chk_gnt("release_idle", 3'b000, 2'b11); chk_data("release_idle_data", 32'hFFFFFFFF, 1'b0);
        data2 = 32'h22225555; req = 3'b100;
        tick(); chk_gnt("regrant2", 3'b100, 2'd2); chk_data("regrant2_data", 32'h22225555, 1'b1);
        req = 3'b001;
        tick(); chk_gnt("direct_switch0", 3'b001, 2'd0); chk_data("direct_switch0_data", 32'hAAAA0000, 1'b1);

        // 6: reset while owner 1 is locked
        req = 3'b010;
        tick(); chk_gnt("switch_to1", 3'b010, 2'd1);
        lock = 1'b1; req = 3'b111; rst = 1'b1;
        tick(); chk_gnt("midreset", 3'b000, 2'b11); chk_data("midreset_data", 32'hFFFFFFFF, 1'b0);
        rst = 1'b0; lock = 1'b0;
        tick(); chk_gnt("post_reset_grant0", 3'b001, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
